sw_array_sequencer: RTL and testbench

- Parametrised successor of the PE-array controller for the Smith-Waterman accelerator; sits between the data processor (query/target buffers) and the systolic PE array.
- Sequences multi-segment alignment:
  - loads a PE_NUM-character query segment;
  - streams the target column (t, v, f) through the array;
  - writes the last-PE boundary column back for the next segment;
  - tracks the global maximum score.
- Supports query lengths beyond one array load and arbitrary target length, which the previous controller did not.

---
 rtl/sw_array_sequencer.sv | 161 ++++++++++++++++
 tb/tb_sw_array_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_array_sequencer.sv
// sw_array_sequencer: multi-segment Smith-Waterman PE-array sequencer.
// Loads query segments, streams targets, writes back boundary columns, tracks the max score.
`default_nettype none

module sw_array_sequencer #(
  parameter int PE_NUM  = 64,
  parameter int SCORE_W = 16,
  parameter int LEN_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic [SCORE_W-1:0]    o_result,
  output logic                  o_valid,
  output logic                  o_overflow,
  input  logic                  i_data_valid,
  output logic                  o_update_s_w,
  input  logic [2*PE_NUM-1:0]   i_s,
  input  logic                  i_s_last,
  output logic                  o_update_t_w,
  input  logic [1:0]            i_t,
  input  logic [SCORE_W-1:0]    i_v,
  input  logic [SCORE_W-1:0]    i_f,
  input  logic                  i_t_last,
  output logic                  o_arr_init,
  output logic [2*PE_NUM-1:0]   o_arr_s,
  output logic                  o_arr_in_valid,
  output logic [1:0]            o_arr_t,
  output logic [SCORE_W-1:0]    o_arr_v,
  output logic [SCORE_W-1:0]    o_arr_f,
  input  logic                  i_arr_out_valid,
  input  logic [1:0]            i_arr_t,
  input  logic [SCORE_W-1:0]    i_arr_v,
  input  logic [SCORE_W-1:0]    i_arr_f,
  input  logic [SCORE_W-1:0]    i_arr_max,
  output logic                  o_wb_valid,
  output logic [1:0]            o_wb_t,
  output logic [SCORE_W-1:0]    o_wb_v,
  output logic [SCORE_W-1:0]    o_wb_f
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SEG_LOAD = 3'd1,
    S_INIT     = 3'd2,
    S_RUN      = 3'd3,
    S_DRAIN    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t             state, state_nx;
  logic [LEN_W-1:0]   in_cnt, out_cnt;
  logic [SCORE_W-1:0] max_score;
  logic               seg_last;
  logic               wb_take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    o_busy       = 1'b1;
    o_valid      = 1'b0;
    o_update_s_w = 1'b0;
    o_update_t_w = 1'b0;
    o_arr_init   = 1'b0;
    case (state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) state_nx = S_SEG_LOAD;
      end
      S_SEG_LOAD: begin
        if (i_data_valid) begin
          o_update_s_w = 1'b1;
          state_nx     = S_INIT;
        end
      end
      S_INIT: begin
        o_arr_init = 1'b1;
        state_nx   = S_RUN;
      end
      S_RUN: begin
        if (i_data_valid) begin
          o_update_t_w = 1'b1;
          if (i_t_last) state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Every forwarded element has returned and nothing is still in flight.
        if (out_cnt == in_cnt && !i_arr_out_valid)
          state_nx = seg_last ? S_DONE : S_SEG_LOAD;
      end
      S_DONE: begin
        o_valid  = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign wb_take = i_arr_out_valid && (state == S_RUN || state == S_DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_result       <= '0;
      o_overflow     <= 1'b0;
      o_arr_s        <= '0;
      o_arr_in_valid <= 1'b0;
      o_arr_t        <= '0;
      o_arr_v        <= '0;
      o_arr_f        <= '0;
      o_wb_valid     <= 1'b0;
      o_wb_t         <= '0;
      o_wb_v         <= '0;
      o_wb_f         <= '0;
      in_cnt         <= '0;
      out_cnt        <= '0;
      max_score      <= '0;
      seg_last       <= 1'b0;
    end else begin
      o_arr_in_valid <= o_update_t_w;
      o_wb_valid     <= wb_take;
      if (o_update_s_w) begin
        o_arr_s  <= i_s;
        seg_last <= i_s_last;
      end
      if (o_update_t_w) begin
        o_arr_t <= i_t;
        o_arr_v <= i_v;
        o_arr_f <= i_f;
        // Saturate rather than wrap so the drain compare stays monotonic.
        if (in_cnt == {LEN_W{1'b1}}) o_overflow <= 1'b1;
        else                         in_cnt     <= in_cnt + 1'b1;
      end
      if (wb_take) begin
        o_wb_t <= i_arr_t;
        o_wb_v <= i_arr_v;
        o_wb_f <= i_arr_f;
        if (out_cnt != {LEN_W{1'b1}}) out_cnt <= out_cnt + 1'b1;
        if (i_arr_max > max_score)    max_score <= i_arr_max;
      end
      if (state == S_INIT) begin
        in_cnt  <= '0;
        out_cnt <= '0;
      end
      if (state == S_IDLE && i_start) begin
        in_cnt     <= '0;
        out_cnt    <= '0;
        max_score  <= '0;
        o_overflow <= 1'b0;
      end
      if (state == S_DRAIN && state_nx == S_DONE) o_result <= max_score;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sw_array_sequencer.sv
// tb_sw_array_sequencer: randomized self-checking bench with a latency-4 array model
// and a queue-based reference for forwarding, write-back, max score and overflow.
`timescale 1ns/1ps
`default_nettype none

module tb_sw_array_sequencer;
  localparam int PE_NUM  = 4;
  localparam int SCORE_W = 16;
  localparam int LEN_W   = 3;
  localparam int LAT     = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_start = 1'b0, i_data_valid = 1'b0, i_s_last = 1'b0, i_t_last = 1'b0;
  logic [2*PE_NUM-1:0] i_s = '0;
  logic [1:0] i_t = '0;
  logic [SCORE_W-1:0] i_v = '0, i_f = '0;
  logic i_arr_out_valid = 1'b0;
  logic [1:0] i_arr_t = '0;
  logic [SCORE_W-1:0] i_arr_v = '0, i_arr_f = '0, i_arr_max = '0;
  logic o_busy, o_valid, o_overflow, o_update_s_w, o_update_t_w, o_arr_init, o_arr_in_valid, o_wb_valid;
  logic [SCORE_W-1:0] o_result, o_arr_v, o_arr_f, o_wb_v, o_wb_f;
  logic [2*PE_NUM-1:0] o_arr_s;
  logic [1:0] o_arr_t, o_wb_t;
  logic [99:0] outs;

  sw_array_sequencer #(.PE_NUM(PE_NUM), .SCORE_W(SCORE_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .o_busy(o_busy), .o_result(o_result),
    .o_valid(o_valid), .o_overflow(o_overflow), .i_data_valid(i_data_valid),
    .o_update_s_w(o_update_s_w), .i_s(i_s), .i_s_last(i_s_last), .o_update_t_w(o_update_t_w),
    .i_t(i_t), .i_v(i_v), .i_f(i_f), .i_t_last(i_t_last), .o_arr_init(o_arr_init),
    .o_arr_s(o_arr_s), .o_arr_in_valid(o_arr_in_valid), .o_arr_t(o_arr_t), .o_arr_v(o_arr_v),
    .o_arr_f(o_arr_f), .i_arr_out_valid(i_arr_out_valid), .i_arr_t(i_arr_t), .i_arr_v(i_arr_v),
    .i_arr_f(i_arr_f), .i_arr_max(i_arr_max), .o_wb_valid(o_wb_valid), .o_wb_t(o_wb_t),
    .o_wb_v(o_wb_v), .o_wb_f(o_wb_f)
  );

  assign outs = {o_busy, o_valid, o_result, o_overflow, o_update_s_w, o_update_t_w, o_arr_init,
                 o_arr_s, o_arr_in_valid, o_arr_t, o_arr_v, o_arr_f, o_wb_valid, o_wb_t, o_wb_v, o_wb_f};

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [1:0]         t;
    logic [SCORE_W-1:0] v;
    logic [SCORE_W-1:0] f;
  } elem_t;

  logic [2*PE_NUM-1:0] seg_s [4];
  int                  seg_len [4];
  logic [1:0]          e_t [4][16];
  logic [SCORE_W-1:0]  e_v [4][16];
  logic [SCORE_W-1:0]  e_f [4][16];

  elem_t exp_in[$];
  elem_t exp_wb[$];
  int    wb_cnt = 0;
  int    init_cnt = 0;
  bit    wb_chk_en = 1'b1;

  // Array model: fixed latency; returns t, v+3, f+1 and a cell max of v^f.
  logic               pv  [LAT];
  logic [1:0]         pt  [LAT];
  logic [SCORE_W-1:0] pvv [LAT];
  logic [SCORE_W-1:0] pf  [LAT];

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        pv[i] = 1'b0; pt[i] = '0; pvv[i] = '0; pf[i] = '0;
      end
    end else begin
      for (int i = LAT-1; i > 0; i--) begin
        pv[i] = pv[i-1]; pt[i] = pt[i-1]; pvv[i] = pvv[i-1]; pf[i] = pf[i-1];
      end
      pv[0] = o_arr_in_valid; pt[0] = o_arr_t; pvv[0] = o_arr_v; pf[0] = o_arr_f;
    end
    i_arr_out_valid = pv[LAT-1];
    i_arr_t   = pt[LAT-1];
    i_arr_v   = pvv[LAT-1] + 16'd3;
    i_arr_f   = pf[LAT-1] + 16'd1;
    // Junk max while idle must never leak into the score.
    i_arr_max = pv[LAT-1] ? (pvv[LAT-1] ^ pf[LAT-1]) : {SCORE_W{1'b1}};
  end

  always @(negedge clk) begin
    elem_t e;
    if (!rst && o_arr_init === 1'b1) init_cnt++;
    if (!rst && o_wb_valid === 1'b1) begin
      wb_cnt++;
      if (wb_chk_en) begin
        total++;
        if (exp_wb.size() == 0) begin
          bad++;
          $display("FAIL wb_extra: got t=%0d v=%0d f=%0d, expected no write-back", o_wb_t, o_wb_v, o_wb_f);
        end else begin
          e = exp_wb.pop_front();
          if ({o_wb_t, o_wb_v, o_wb_f} !== e) begin
            bad++;
            $display("FAIL wb_data: got t=%0d v=%0d f=%0d, expected t=%0d v=%0d f=%0d",
                     o_wb_t, o_wb_v, o_wb_f, e.t, e.v, e.f);
          end
        end
      end
    end
  end

  task automatic fill_random(input int nseg, input int minlen, input int maxlen);
    for (int s = 0; s < nseg; s++) begin
      seg_s[s]   = 8'($urandom);
      seg_len[s] = $urandom_range(minlen, maxlen);
      for (int k = 0; k < 16; k++) begin
        e_t[s][k] = 2'($urandom);
        e_v[s][k] = 16'($urandom);
        e_f[s][k] = 16'($urandom);
      end
    end
  endtask

  // One complete job: start, feed segments/targets, check everything up to o_valid.
  task automatic run_job(input int nseg, input int dv_mode, input int start_at,
                         input int rst_after, input bit exp_ovf, input bit chk_res);
    int seg, el, cyc, after_last, wb_expect;
    bit upd_s, upd_t, prev_upd, done, chk_s, aborted, start_done;
    logic [SCORE_W-1:0] exp_max, sc;
    elem_t e;
    seg = 0; el = 0; cyc = 0; after_last = -1; wb_expect = 0;
    prev_upd = 0; done = 0; chk_s = 0; aborted = 0; start_done = 0; exp_max = '0;
    wb_cnt = 0; init_cnt = 0;
    exp_in.delete(); exp_wb.delete();
    while (!done && cyc < 3000) begin
      if (seg < nseg) begin
        i_s = seg_s[seg]; i_s_last = (seg == nseg-1);
        i_t = e_t[seg][el]; i_v = e_v[seg][el]; i_f = e_f[seg][el];
        i_t_last = (el == seg_len[seg]-1);
      end else begin
        i_t_last = 1'b0;
      end
      case (dv_mode)
        0:       i_data_valid = ($urandom_range(0, 3) != 0);
        1:       i_data_valid = (cyc % 2 == 0);
        default: i_data_valid = 1'b1;
      endcase
      i_start = (cyc == 0);
      if (start_at >= 0 && !start_done && cyc > 0 && exp_in.size() + wb_cnt >= start_at && seg == 0 && el > 0) begin
        i_start = 1'b1; start_done = 1;
      end
      @(negedge clk);
      if (rst_after > 0 && after_last == rst_after) begin
        total++;
        if (o_busy !== 1'b1 || o_valid !== 1'b0) begin
          bad++; $display("FAIL drain_state: busy=%0b valid=%0b, expected busy=1 valid=0", o_busy, o_valid);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (outs !== '0) begin
          bad++; $display("FAIL async_reset: outputs=%h, expected all zero", outs);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        aborted = 1;
        break;
      end
      if (cyc >= 1) begin
        total++;
        if (o_busy !== 1'b1) begin bad++; $display("FAIL busy: got %0b at cycle %0d, expected 1", o_busy, cyc); end
      end
      if (cyc == 1) begin
        total++;
        if (o_overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %0b, expected 0 after start", o_overflow); end
      end
      total++;
      if (o_arr_in_valid !== prev_upd) begin
        bad++; $display("FAIL in_valid_delay: got %0b, expected %0b", o_arr_in_valid, prev_upd);
      end
      if (o_update_t_w === 1'b1) begin
        total++;
        if (i_data_valid !== 1'b1) begin bad++; $display("FAIL pop_no_valid: got pop=1 with data_valid=%0b, expected no pop", i_data_valid); end
      end
      if (o_arr_in_valid === 1'b1 && exp_in.size() > 0) begin
        e = exp_in.pop_front();
        total++;
        if ({o_arr_t, o_arr_v, o_arr_f} !== e) begin
          bad++; $display("FAIL arr_in: got t=%0d v=%0d f=%0d, expected t=%0d v=%0d f=%0d", o_arr_t, o_arr_v, o_arr_f, e.t, e.v, e.f);
        end
      end
      if (chk_s) begin
        chk_s = 0;
        total++;
        if (o_arr_s !== seg_s[seg]) begin bad++; $display("FAIL arr_s: got %h, expected %h", o_arr_s, seg_s[seg]); end
      end
      if (o_update_s_w === 1'b1 && wb_chk_en) begin
        total++;
        if (wb_cnt !== wb_expect) begin bad++; $display("FAIL seg_order: %0d write-backs before segment load, expected %0d", wb_cnt, wb_expect); end
      end
      if (o_valid === 1'b1) begin
        done = 1;
        if (chk_res) begin
          total++;
          if (o_result !== exp_max) begin bad++; $display("FAIL result: got %0d, expected %0d", o_result, exp_max); end
        end
        total++;
        if (o_overflow !== exp_ovf) begin bad++; $display("FAIL overflow: got %0b, expected %0b", o_overflow, exp_ovf); end
        total++;
        if (init_cnt !== nseg) begin bad++; $display("FAIL init_count: got %0d, expected %0d", init_cnt, nseg); end
        total++;
        if (exp_in.size() != 0) begin bad++; $display("FAIL arr_in_count: %0d elements never forwarded, expected 0", exp_in.size()); end
        if (wb_chk_en) begin
          total++;
          if (wb_cnt !== wb_expect || exp_wb.size() != 0) begin
            bad++; $display("FAIL wb_count: got %0d, expected %0d", wb_cnt, wb_expect);
          end
        end
      end
      upd_s = o_update_s_w;
      upd_t = o_update_t_w;
      @(posedge clk);
      #1;
      prev_upd = upd_t;
      if (upd_s) chk_s = 1;
      if (after_last >= 0) after_last++;
      if (upd_t && seg < nseg) begin
        e.t = e_t[seg][el]; e.v = e_v[seg][el]; e.f = e_f[seg][el];
        exp_in.push_back(e);
        sc = e.v ^ e.f;
        if (sc > exp_max) exp_max = sc;
        e.v = e.v + 16'd3; e.f = e.f + 16'd1;
        exp_wb.push_back(e);
        el++;
        if (el == seg_len[seg]) begin
          wb_expect += seg_len[seg];
          el = 0; seg++;
          if (seg == nseg) after_last = 0;
        end
      end
      cyc++;
    end
    i_start = 1'b0;
    i_data_valid = 1'b0;
    if (aborted) begin
      @(posedge clk); #1;
    end else if (!done) begin
      total++; bad++;
      $display("FAIL timeout: no o_valid after %0d cycles, expected completion", cyc);
    end else begin
      @(negedge clk);
      total++;
      if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
        bad++; $display("FAIL after_done: valid=%0b busy=%0b, expected 0 0", o_valid, o_busy);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_data_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (outs !== '0) begin bad++; $display("FAIL reset_outputs: got %h, expected all zero", outs); end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (outs !== '0) begin bad++; $display("FAIL idle_outputs: got %h, expected all zero", outs); end
    i_data_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_segment();
    fill_random(1, 3, 3);
    e_v[0][0] = 16'd5; e_v[0][1] = 16'd9; e_v[0][2] = 16'd7;
    e_f[0][0] = 16'd0; e_f[0][1] = 16'd0; e_f[0][2] = 16'd0;
    run_job(1, 2, -1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_two_segments();
    fill_random(2, 5, 5);
    run_job(2, 0, -1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_valid_toggle();
    fill_random(1, 4, 4);
    run_job(1, 1, -1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_start_ignored();
    fill_random(2, 5, 6);
    run_job(2, 2, 2, 0, 1'b0, 1'b1);
  endtask

  task automatic test_single_element();
    fill_random(2, 1, 1);
    run_job(2, 2, -1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_random_jobs();
    for (int k = 0; k < 6; k++) begin
      int ns;
      ns = $urandom_range(1, 3);
      fill_random(ns, 1, 7);
      run_job(ns, k % 3, -1, 0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_reset_in_drain();
    fill_random(1, 5, 5);
    run_job(1, 2, -1, 2, 1'b0, 1'b0);
    fill_random(2, 3, 7);
    run_job(2, 0, -1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_overflow();
    fill_random(1, 9, 9);
    wb_chk_en = 1'b0;
    run_job(1, 2, -1, 0, 1'b1, 1'b0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    total++;
    if (o_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %0b, expected 1", o_overflow); end
    @(posedge clk); #1;
    wb_chk_en = 1'b1;
    fill_random(1, 7, 7);
    run_job(1, 2, -1, 0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_single_segment();
    test_two_segments();
    test_valid_toggle();
    test_start_ignored();
    test_single_element();
    test_random_jobs();
    test_reset_in_drain();
    test_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
